// File: rtl/fetch_ctrl_if.sv
// Control bundle between fetch_ctrl and the debug unit, ID-stage decode and fetch stage.
// master = fetch_ctrl itself, slave = the surrounding pipeline/debug logic.
interface fetch_ctrl_if #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
);
  logic              i_dbg_run;
  logic              i_dbg_step;
  logic              i_dbg_halt;
  logic              i_halt_instr;
  logic              i_branch_taken;
  logic              i_jump;
  logic              i_id_ex_mem_read;
  logic [NB_REG-1:0] i_id_ex_rt;
  logic [NB_REG-1:0] i_if_id_rs;
  logic [NB_REG-1:0] i_if_id_rt;
  logic              i_if_id_uses_rt;
  logic              o_pc_we;
  logic              o_if_id_we;
  logic              o_ctr_flush;
  logic              o_ctr_beq;
  logic              o_ctr_jmp;
  logic              o_id_ex_bubble;
  logic              o_pipe_en;
  logic              o_halted;
  logic [NB_CNT-1:0] o_cycle_cnt;

  modport master (
    input  i_dbg_run, i_dbg_step, i_dbg_halt, i_halt_instr, i_branch_taken, i_jump,
           i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt, i_if_id_uses_rt,
    output o_pc_we, o_if_id_we, o_ctr_flush, o_ctr_beq, o_ctr_jmp, o_id_ex_bubble,
           o_pipe_en, o_halted, o_cycle_cnt
  );

  modport slave (
    output i_dbg_run, i_dbg_step, i_dbg_halt, i_halt_instr, i_branch_taken, i_jump,
           i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt, i_if_id_uses_rt,
    input  o_pc_we, o_if_id_we, o_ctr_flush, o_ctr_beq, o_ctr_jmp, o_id_ex_bubble,
           o_pipe_en, o_halted, o_cycle_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: debug run/step/halt FSM, HALT drain, load-use stall and
// branch/jump redirect control for the PC and IF/ID register.
module fetch_ctrl #(
  parameter int NB_REG       = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_ctrl_if.master  bus
);

  localparam int NB_DRN = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DRN-1:0]   drain_q, drain_d;
  logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;

  logic load_use;
  logic active;
  logic pc_we, if_id_we, flush, beq, jmp, bubble, pipe_en, halted;

  // x0 is never a real hazard: writes to it are discarded.
  assign load_use = bus.i_id_ex_mem_read
                 && (bus.i_id_ex_rt != {NB_REG{1'b0}})
                 && ((bus.i_id_ex_rt == bus.i_if_id_rs)
                     || (bus.i_if_id_uses_rt && (bus.i_id_ex_rt == bus.i_if_id_rt)));

  assign active = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cycle_cnt_d = cycle_cnt_q;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    flush       = 1'b0;
    beq         = 1'b0;
    jmp         = 1'b0;
    bubble      = 1'b0;
    pipe_en     = 1'b0;
    halted      = 1'b0;

    if (active && !(&cycle_cnt_q)) begin
      cycle_cnt_d = cycle_cnt_q + NB_CNT'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.i_dbg_run) begin
          state_d = RUN;
        end else if (bus.i_dbg_step) begin
          state_d = STEP;
        end
      end
      RUN, STEP: begin
        pipe_en = 1'b1;
        if (bus.i_halt_instr) begin
          // Freeze PC on the HALT and let the older instructions retire.
          if_id_we = 1'b1;
          flush    = 1'b1;
          state_d  = DRAIN;
          drain_d  = NB_DRN'(DRAIN_CYCLES);
        end else begin
          if (load_use) begin
            bubble = 1'b1;
          end else if (bus.i_jump) begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            jmp      = 1'b1;
            flush    = 1'b1;
          end else if (bus.i_branch_taken) begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            beq      = 1'b1;
            flush    = 1'b1;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
          end
          if ((state_q == STEP) || bus.i_dbg_halt) begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        pipe_en  = 1'b1;
        if_id_we = 1'b1;
        flush    = 1'b1;
        drain_d  = drain_q - NB_DRN'(1);
        if (drain_q == NB_DRN'(1)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.o_pc_we        = pc_we;
  assign bus.o_if_id_we     = if_id_we;
  assign bus.o_ctr_flush    = flush;
  assign bus.o_ctr_beq      = beq;
  assign bus.o_ctr_jmp      = jmp;
  assign bus.o_id_ex_bubble = bubble;
  assign bus.o_pipe_en      = pipe_en;
  assign bus.o_halted       = halted;
  assign bus.o_cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then randomized episodes, all checked against
// a mode-level reference model plus a small fetch-PC stub driven by the DUT outputs.
module tb_fetch_ctrl;

  localparam int NB_REG   = 5;
  localparam int NB_CNT   = 32;
  localparam int N_DRAIN  = 3;
  localparam logic [31:0] JMP_ADDR = 32'd100;
  localparam logic [31:0] BR_TGT   = 32'd40;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_DRAIN  = 3;
  localparam int M_HALTED = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) bus ();

  fetch_ctrl #(.NB_REG(NB_REG), .NB_CNT(NB_CNT), .DRAIN_CYCLES(N_DRAIN)) u_dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  // Minimal fetch stage consuming the controller outputs.
  logic [31:0] pc_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_q <= 32'd0;
    else if (bus.o_pc_we)  pc_q <= bus.o_ctr_jmp ? JMP_ADDR : (bus.o_ctr_beq ? BR_TGT : pc_q + 32'd4);
  end

  int n_vec = 0;
  int n_err = 0;

  int              m_mode;
  int              m_drain;
  logic [NB_CNT-1:0] m_cnt;
  logic [31:0]     m_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs_vec();
    return {bus.o_pc_we, bus.o_if_id_we, bus.o_ctr_flush, bus.o_ctr_beq,
            bus.o_ctr_jmp, bus.o_id_ex_bubble, bus.o_pipe_en, bus.o_halted};
  endfunction

  // Expected {pc_we, if_id_we, flush, beq, jmp, bubble, pipe_en, halted}.
  function automatic logic [7:0] expect_outs();
    logic stall;
    stall = bus.i_id_ex_mem_read && (bus.i_id_ex_rt != 0) &&
            ((bus.i_id_ex_rt == bus.i_if_id_rs) ||
             (bus.i_if_id_uses_rt && (bus.i_id_ex_rt == bus.i_if_id_rt)));
    if (m_mode == M_HALTED) return 8'b0000_0001;
    if (m_mode == M_DRAIN)  return 8'b0110_0010;
    if (m_mode == M_IDLE)   return 8'b0000_0000;
    if (bus.i_halt_instr)   return 8'b0110_0010;
    if (stall)              return 8'b0000_0110;
    if (bus.i_jump)         return 8'b1110_1010;
    if (bus.i_branch_taken) return 8'b1111_0010;
    return 8'b1100_0010;
  endfunction

  task automatic model_step(input logic [7:0] e);
    if ((m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN) && m_cnt != '1)
      m_cnt = m_cnt + 1;
    if (e[7]) m_pc = e[3] ? JMP_ADDR : (e[4] ? BR_TGT : m_pc + 32'd4);
    case (m_mode)
      M_IDLE: begin
        if (bus.i_dbg_run)       m_mode = M_RUN;
        else if (bus.i_dbg_step) m_mode = M_STEP;
      end
      M_RUN, M_STEP: begin
        if (bus.i_halt_instr) begin
          m_mode  = M_DRAIN;
          m_drain = N_DRAIN;
        end else if (m_mode == M_STEP || bus.i_dbg_halt) begin
          m_mode = M_IDLE;
        end
      end
      M_DRAIN: begin
        m_drain--;
        if (m_drain == 0) m_mode = M_HALTED;
      end
      default: ;
    endcase
  endtask

  task automatic clear_inputs();
    bus.i_dbg_run        = 1'b0;
    bus.i_dbg_step       = 1'b0;
    bus.i_dbg_halt       = 1'b0;
    bus.i_halt_instr     = 1'b0;
    bus.i_branch_taken   = 1'b0;
    bus.i_jump           = 1'b0;
    bus.i_id_ex_mem_read = 1'b0;
    bus.i_id_ex_rt       = '0;
    bus.i_if_id_rs       = '0;
    bus.i_if_id_rt       = '0;
    bus.i_if_id_uses_rt  = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    #1;
    e = expect_outs();
    g = outs_vec();
    chk({tag, "/outs"}, 64'(g), 64'(e));
    @(posedge clk);
    model_step(e);
    #1;
    chk({tag, "/cnt"}, 64'(bus.o_cycle_cnt), 64'(m_cnt));
    chk({tag, "/pc"}, 64'(pc_q), 64'(m_pc));
    $display("[%0t] %-12s outs=%b cnt=%0d pc=%0d", $time, tag, g, bus.o_cycle_cnt, pc_q);
    @(negedge clk);
    clear_inputs();
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_mode = M_IDLE; m_drain = 0; m_cnt = '0; m_pc = 32'd0;
    chk({tag, "/outs"}, 64'(outs_vec()), 64'(8'b0));
    chk({tag, "/cnt"}, 64'(bus.o_cycle_cnt), 64'(m_cnt));
    $display("[%0t] %-12s reset asserted outs=%b cnt=%0d", $time, tag, outs_vec(), bus.o_cycle_cnt);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    m_mode = M_IDLE; m_drain = 0; m_cnt = '0; m_pc = 32'd0;
    @(negedge clk);
    apply_reset("por");

    // Single step: one active cycle, PC +4, back to IDLE.
    bus.i_dbg_step = 1'b1;
    tick("t1_step");
    tick("t1_idle");

    // Load-use stall, then same pattern with x0 destination.
    bus.i_dbg_run = 1'b1;
    tick("t2_run");
    bus.i_id_ex_mem_read = 1'b1; bus.i_id_ex_rt = 5'd8; bus.i_if_id_rs = 5'd8;
    tick("t2_stall");
    bus.i_id_ex_mem_read = 1'b1; bus.i_id_ex_rt = 5'd0; bus.i_if_id_rs = 5'd0;
    tick("t2_rt0");

    // Jump beats branch.
    bus.i_jump = 1'b1; bus.i_branch_taken = 1'b1;
    tick("t3_jmp_beq");

    // Branch held under stall (rt match), taken next cycle.
    bus.i_id_ex_mem_read = 1'b1; bus.i_id_ex_rt = 5'd5; bus.i_if_id_rt = 5'd5;
    bus.i_if_id_uses_rt = 1'b1; bus.i_if_id_rs = 5'd1; bus.i_branch_taken = 1'b1;
    tick("t4_stall_br");
    bus.i_branch_taken = 1'b1;
    tick("t4_beq");

    // HALT instruction: drain then sticky halt.
    bus.i_halt_instr = 1'b1;
    tick("t5_halt_ins");
    for (int i = 0; i < N_DRAIN; i++) begin
      bus.i_jump = 1'b1; bus.i_dbg_halt = 1'b1;
      tick("t5_drain");
    end
    bus.i_dbg_run = 1'b1;
    tick("t5_run_ign");
    bus.i_dbg_step = 1'b1;
    tick("t5_step_ign");

    // Async reset mid-run, then debug halt/resume.
    apply_reset("t6_rst0");
    bus.i_dbg_run = 1'b1;
    tick("t6_run");
    tick("t6_run");
    apply_reset("t6_rst_mid");
    bus.i_dbg_run = 1'b1;
    tick("t6_run");
    tick("t6_run");
    bus.i_dbg_halt = 1'b1;
    tick("t6_dbg_halt");
    bus.i_dbg_halt = 1'b1;
    tick("t6_idle");
    bus.i_dbg_run = 1'b1; bus.i_dbg_step = 1'b1;
    tick("t6_resume");
    tick("t6_run");

    // Randomized episodes.
    for (int ep = 0; ep < 6; ep++) begin
      apply_reset("rnd_rst");
      for (int c = 0; c < 60; c++) begin
        bus.i_dbg_run        = ($urandom_range(0, 7) == 0);
        bus.i_dbg_step       = ($urandom_range(0, 7) == 0);
        bus.i_dbg_halt       = ($urandom_range(0, 11) == 0);
        bus.i_halt_instr     = ($urandom_range(0, 39) == 0);
        bus.i_branch_taken   = ($urandom_range(0, 3) == 0);
        bus.i_jump           = ($urandom_range(0, 4) == 0);
        bus.i_id_ex_mem_read = ($urandom_range(0, 2) == 0);
        bus.i_id_ex_rt       = NB_REG'($urandom_range(0, 3));
        bus.i_if_id_rs       = NB_REG'($urandom_range(0, 3));
        bus.i_if_id_rt       = NB_REG'($urandom_range(0, 3));
        bus.i_if_id_uses_rt  = 1'($urandom_range(0, 1));
        tick("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing and hazard controller for the MIPS fetch stage and IF/ID register. Drives Fetch_module's PC write-enable, IF/ID write-enable, flush, branch-select and jump-select. Runs a debug run/step/halt state machine and detects load-use hazards. Sits between the ID-stage decode/compare logic, the debug unit and the fetch stage.

Parameters:
NB_REG, 5, register-address width
NB_CNT, 32, active-cycle counter width
DRAIN_CYCLES, 3, cycles needed to retire in-flight instructions after a HALT (EX, MEM, WB)

Ports:
i_clk  in  1  clock; all state updates on its rising edge
i_rst  in  1  reset; asynchronous, active-low
i_dbg_run  in  1  pulse; start continuous execution
i_dbg_step  in  1  pulse; execute exactly one pipeline cycle
i_dbg_halt  in  1  pulse; pause execution (resumable)
i_halt_instr  in  1  HALT opcode decoded in ID
i_branch_taken  in  1  beq resolved taken in ID
i_jump  in  1  jump decoded in ID
i_id_ex_mem_read  in  1  instruction in EX is a load
i_id_ex_rt  in  NB_REG  load destination register
i_if_id_rs  in  NB_REG  ID source register rs
i_if_id_rt  in  NB_REG  ID source register rt
i_if_id_uses_rt  in  1  ID instruction reads rt
o_pc_we  out  1  PC write-enable
o_if_id_we  out  1  IF/ID write-enable
o_ctr_flush  out  1  clear IF/ID to NOP
o_ctr_beq  out  1  select branch target
o_ctr_jmp  out  1  select jump target
o_id_ex_bubble  out  1  inject NOP into ID/EX
o_pipe_en  out  1  global enable for ID/EX and later stages
o_halted  out  1  processor halted (terminal)
o_cycle_cnt  out  NB_CNT  count of active cycles

Behaviour:
- States: IDLE, RUN, STEP, DRAIN, HALTED. Reset (i_rst=0, asynchronous) -> IDLE, drain counter 0, o_cycle_cnt 0. All outputs are 0 while in reset and in IDLE.
- Active cycle: state is RUN, STEP or DRAIN. o_pipe_en=1 only in active cycles.
- IDLE:
  - i_dbg_run -> RUN.
  - Else i_dbg_step -> STEP.
  - i_dbg_halt is ignored.
  - When run and step arrive together, run wins.
- RUN / STEP:
  - Priority 1: i_halt_instr -> DRAIN. That cycle: pc_we=0, if_id_we=1, flush=1, bubble=0, beq=jmp=0. The drain counter loads DRAIN_CYCLES.
  - Otherwise RUN moves to IDLE if i_dbg_halt, else stays in RUN. STEP always returns to IDLE after its single cycle.
  - Outputs in a RUN/STEP cycle without halt_instr are evaluated combinationally with this priority:
    1. Load-use stall = i_id_ex_mem_read and i_id_ex_rt!=0 and (i_id_ex_rt==i_if_id_rs or (i_if_id_uses_rt and i_id_ex_rt==i_if_id_rt)). Gives pc_we=0, if_id_we=0, bubble=1, flush=0, beq=jmp=0. A branch or jump in ID is held, not taken.
    2. i_jump: pc_we=1, if_id_we=1, jmp=1, flush=1, beq=0.
    3. i_branch_taken: pc_we=1, if_id_we=1, beq=1, flush=1.
    4. None of the above: pc_we=1, if_id_we=1, all others 0.
  - o_ctr_beq and o_ctr_jmp are never both 1.
- DRAIN:
  - Outputs: pc_we=0, if_id_we=1, flush=1, pipe_en=1; all hazard inputs and debug pulses are ignored.
  - The counter decrements each cycle. When it reads 1, the next state is HALTED, so DRAIN lasts exactly DRAIN_CYCLES cycles.
- HALTED: o_halted=1, all other outputs 0. Sticky until reset; debug pulses are ignored.
- o_cycle_cnt: +1 on each rising edge that ends an active cycle; saturates at all-ones.
- Reset asserted mid-operation (any state) -> immediate return to IDLE with counters cleared.

Test Plan:
1. Reset release, then i_dbg_step pulse -> exactly one cycle with o_pc_we=1, o_pipe_en=1; back in IDLE with o_cycle_cnt=1, PC advanced by 4.
2. RUN, with i_id_ex_mem_read=1, i_id_ex_rt=8, i_if_id_rs=8 for one cycle -> o_pc_we=0, o_if_id_we=0, o_id_ex_bubble=1. Repeat with i_id_ex_rt=0 -> no stall.
3. RUN, i_jump=1 and i_branch_taken=1 in the same cycle -> o_ctr_jmp=1, o_ctr_beq=0, o_ctr_flush=1; fetch loads i_jmp_addr=100.
4. RUN, load-use stall together with i_branch_taken=1 -> o_ctr_beq=0. The next cycle, with no stall, gives o_ctr_beq=1 and the fetch PC becomes 40.
5. RUN, i_halt_instr=1 -> DRAIN for 3 cycles with o_pc_we=0 and o_ctr_flush=1, then o_halted=1. A subsequent i_dbg_run causes no change.
6. RUN, then i_rst=0 mid-cycle (between clock edges) -> outputs go to 0 immediately and o_cycle_cnt=0. i_dbg_halt in RUN -> IDLE, and a later i_dbg_run resumes with the count intact.
